// File: rtl/rx_psdu_byte_sequencer.sv
// rtl/rx_psdu_byte_sequencer.sv - RX PSDU bit-to-byte sequencer: SERVICE skip, LSB-first packing, length tracking
module rx_psdu_byte_sequencer #(
  parameter int SERVICE_BITS = 16,
  parameter int LEN_WIDTH    = 16,
  parameter int MAX_LEN      = 4095
) (
  input  logic                 clock,
  input  logic                 rstn,
  input  logic                 enable,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] pkt_len,
  input  logic                 bit_in,
  input  logic                 input_strobe,
  output logic [7:0]           byte_out,
  output logic                 output_strobe,
  output logic [LEN_WIDTH-1:0] byte_count,
  output logic                 busy,
  output logic                 pkt_done,
  output logic                 len_err
);

  localparam int SKIP_W = (SERVICE_BITS > 1) ? $clog2(SERVICE_BITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SKIP,
    S_PACK
  } state_t;

  state_t               state;
  logic [LEN_WIDTH-1:0] len_q;
  logic [SKIP_W-1:0]    skip_cnt;
  logic [2:0]           bit_cnt;
  logic [7:0]           shift_buf;
  logic [LEN_WIDTH-1:0] count_inc;
  logic [7:0]           next_byte;
  logic                 len_ok;

  // Helpers: next byte count, next packed byte, and start-length acceptance.
  assign count_inc = byte_count + LEN_WIDTH'(1);
  assign next_byte = {bit_in, shift_buf[7:1]};
  assign len_ok    = (pkt_len != '0) && (pkt_len <= LEN_WIDTH'(MAX_LEN));

  // Packet sequencing FSM; all outputs are registered here. A start always
  // takes priority over a bit in the same cycle, and aborts any packet in flight.
  always_ff @(posedge clock) begin
    if (!rstn) begin
      state         <= S_IDLE;
      len_q         <= '0;
      skip_cnt      <= '0;
      bit_cnt       <= '0;
      shift_buf     <= '0;
      byte_out      <= '0;
      output_strobe <= 1'b0;
      byte_count    <= '0;
      busy          <= 1'b0;
      pkt_done      <= 1'b0;
      len_err       <= 1'b0;
    end else begin
      output_strobe <= 1'b0;
      pkt_done      <= 1'b0;
      len_err       <= 1'b0;
      if (enable) begin
        if (start) begin
          skip_cnt  <= '0;
          bit_cnt   <= '0;
          shift_buf <= '0;
          if (len_ok) begin
            len_q      <= pkt_len;
            byte_count <= '0;
            state      <= S_SKIP;
            busy       <= 1'b1;
          end else begin
            len_err <= 1'b1;
            state   <= S_IDLE;
            busy    <= 1'b0;
          end
        end else if (input_strobe) begin
          case (state)
            S_IDLE: begin
              // Tail and pad bits land here and are dropped.
            end
            S_SKIP: begin
              if (skip_cnt == SKIP_W'(SERVICE_BITS - 1)) begin
                state   <= S_PACK;
                bit_cnt <= '0;
              end else begin
                skip_cnt <= skip_cnt + SKIP_W'(1);
              end
            end
            S_PACK: begin
              shift_buf <= next_byte;
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                byte_out      <= next_byte;
                output_strobe <= 1'b1;
                byte_count    <= count_inc;
                if (count_inc == len_q) begin
                  pkt_done <= 1'b1;
                  state    <= S_IDLE;
                  busy     <= 1'b0;
                end
              end
            end
            default: begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_psdu_byte_sequencer.sv
// tb/tb_rx_psdu_byte_sequencer.sv - self-checking bench for rx_psdu_byte_sequencer
module tb_rx_psdu_byte_sequencer;

  logic        clock = 1'b0;
  logic        rstn;
  logic        enable;
  logic        start;
  logic [15:0] pkt_len;
  logic        bit_in;
  logic        input_strobe;
  logic [7:0]  byte_out;
  logic        output_strobe;
  logic [15:0] byte_count;
  logic        busy;
  logic        pkt_done;
  logic        len_err;

  rx_psdu_byte_sequencer dut (
    .clock         (clock),
    .rstn          (rstn),
    .enable        (enable),
    .start         (start),
    .pkt_len       (pkt_len),
    .bit_in        (bit_in),
    .input_strobe  (input_strobe),
    .byte_out      (byte_out),
    .output_strobe (output_strobe),
    .byte_count    (byte_count),
    .busy          (busy),
    .pkt_done      (pkt_done),
    .len_err       (len_err)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: packet view (bits received since start, bytes owed).
  bit       m_active;
  int       m_len;
  int       m_nbits;
  int       m_count;
  bit [7:0] m_acc;
  bit [7:0] m_byte;
  bit       m_strobe;
  bit       m_done;
  bit       m_lerr;

  // DUT observation log.
  int       n_strobe = 0;
  int       n_done   = 0;
  int       n_lerr   = 0;
  bit [7:0] got[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_len = 0; m_nbits = 0; m_count = 0;
    m_acc = 0; m_byte = 0; m_strobe = 0; m_done = 0; m_lerr = 0;
  endtask

  // One clock: apply inputs, update model, check all outputs after the edge.
  task automatic step(input logic st, input int len, input logic b, input logic s, input logic en);
    int idx;
    start = st; pkt_len = 16'(len); bit_in = b; input_strobe = s; enable = en;
    @(posedge clock);
    if (!rstn) begin
      model_reset();
    end else if (en) begin
      m_strobe = 0; m_done = 0; m_lerr = 0;
      if (st) begin
        if (len >= 1 && len <= 4095) begin
          m_active = 1; m_len = len; m_nbits = 0; m_count = 0; m_acc = 0;
        end else begin
          m_lerr = 1; m_active = 0;
        end
      end else if (s && m_active) begin
        m_nbits++;
        if (m_nbits > 16) begin
          idx = (m_nbits - 17) % 8;
          m_acc[idx] = b;
          if (idx == 7) begin
            m_byte = m_acc; m_acc = 0; m_strobe = 1; m_count++;
            if (m_count == m_len) begin
              m_done = 1; m_active = 0;
            end
          end
        end
      end
    end else begin
      m_strobe = 0; m_done = 0; m_lerr = 0;
    end
    #1;
    chk("output_strobe", {31'd0, output_strobe}, {31'd0, m_strobe});
    chk("pkt_done",      {31'd0, pkt_done},      {31'd0, m_done});
    chk("len_err",       {31'd0, len_err},       {31'd0, m_lerr});
    chk("busy",          {31'd0, busy},          {31'd0, m_active});
    chk("byte_count",    {16'd0, byte_count},    32'(m_count));
    chk("byte_out",      {24'd0, byte_out},      {24'd0, m_byte});
    if (output_strobe) begin n_strobe++; got.push_back(byte_out); end
    if (pkt_done) n_done++;
    if (len_err) n_lerr++;
  endtask

  task automatic do_start(input int len);
    step(1'b1, len, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic send_bit(input logic b);
    step(1'b0, 0, b, 1'b1, 1'b1);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic send_service();
    for (int i = 0; i < 16; i++) send_bit(1'b1);
  endtask

  task automatic send_bit_gapped(input logic b);
    int gap;
    gap = $urandom_range(0, 2);
    for (int g = 0; g < gap; g++) step(1'b0, 0, 1'($urandom), 1'b0, 1'b1);
    send_bit(b);
  endtask

  int        s0, d0, e0;
  bit [7:0]  data[$];
  bit [7:0]  v;
  bit [7:0]  tmp;

  initial begin
    rstn = 1'b0;
    model_reset();
    step(1'b0, 0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);
    rstn = 1'b1;

    // pkt_len=1, byte 0x05
    s0 = n_strobe; d0 = n_done; got.delete();
    do_start(1);
    send_service();
    send_byte(8'h05);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);
    chk("t1_strobes", 32'(n_strobe - s0), 32'd1);
    chk("t1_done", 32'(n_done - d0), 32'd1);
    tmp = got[0];
    chk("t1_byte", {24'd0, tmp}, 32'h05);
    chk("t1_count", {16'd0, byte_count}, 32'd1);
    chk("t1_busy", {31'd0, busy}, 32'd0);

    // pkt_len=3 plus tail bits
    s0 = n_strobe; d0 = n_done; got.delete();
    do_start(3);
    send_service();
    send_byte(8'hA5); send_byte(8'h3C); send_byte(8'hFF);
    for (int i = 0; i < 10; i++) send_bit(1'($urandom));
    chk("t2_strobes", 32'(n_strobe - s0), 32'd3);
    chk("t2_done", 32'(n_done - d0), 32'd1);
    tmp = got[0]; chk("t2_b0", {24'd0, tmp}, 32'hA5);
    tmp = got[1]; chk("t2_b1", {24'd0, tmp}, 32'h3C);
    tmp = got[2]; chk("t2_b2", {24'd0, tmp}, 32'hFF);

    // rejected lengths
    s0 = n_strobe; e0 = n_lerr;
    do_start(0);
    for (int i = 0; i < 30; i++) send_bit(1'($urandom));
    do_start(4096);
    for (int i = 0; i < 30; i++) send_bit(1'($urandom));
    chk("t3_lerr", 32'(n_lerr - e0), 32'd2);
    chk("t3_strobes", 32'(n_strobe - s0), 32'd0);

    // abort with restart
    d0 = n_done; got.delete();
    do_start(4);
    send_service();
    send_byte(8'h11); send_byte(8'h22);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    do_start(1);
    chk("t4_abort_done", 32'(n_done - d0), 32'd0);
    chk("t4_count_clr", {16'd0, byte_count}, 32'd0);
    send_service();
    send_byte(8'h9B);
    chk("t4_done", 32'(n_done - d0), 32'd1);
    chk("t4_count", {16'd0, byte_count}, 32'd1);
    tmp = got[2]; chk("t4_byte", {24'd0, tmp}, 32'h9B);

    // gapped random packets with enable dropped mid-byte and a masked start
    for (int p = 0; p < 4; p++) begin
      int len;
      len = $urandom_range(1, 6);
      data.delete(); got.delete(); d0 = n_done;
      do_start(len);
      for (int i = 0; i < 16; i++) send_bit_gapped(1'($urandom));
      for (int k = 0; k < len; k++) begin
        v = 8'($urandom);
        data.push_back(v);
        for (int i = 0; i < 8; i++) begin
          if (k == 0 && i == 3) begin
            step(1'b1, 2, 1'b1, 1'b1, 1'b0);
            step(1'b0, 0, 1'b0, 1'b1, 1'b0);
            step(1'b1, 0, 1'b1, 1'b1, 1'b0);
          end
          send_bit_gapped(v[i]);
        end
      end
      chk("t5_nbytes", 32'(got.size()), 32'(len));
      for (int k = 0; k < len && k < got.size(); k++)
        chk("t5_byte", {24'd0, got[k]}, {24'd0, data[k]});
      chk("t5_done", 32'(n_done - d0), 32'd1);
    end

    // reset after 12 bytes of 20
    d0 = n_done;
    do_start(20);
    send_service();
    for (int k = 0; k < 12; k++) send_byte(8'($urandom));
    rstn = 1'b0;
    step(1'b0, 0, 1'b1, 1'b1, 1'b1);
    rstn = 1'b1;
    chk("t6_count", {16'd0, byte_count}, 32'd0);
    chk("t6_byte", {24'd0, byte_out}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_no_done", 32'(n_done - d0), 32'd0);
    got.delete();
    do_start(2);
    send_service();
    send_byte(8'hC3); send_byte(8'h5A);
    chk("t6_done", 32'(n_done - d0), 32'd1);
    chk("t6_nbytes", 32'(got.size()), 32'd2);
    tmp = got[1]; chk("t6_b1", {24'd0, tmp}, 32'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
